// File: rtl/data_cache.sv
`timescale 1ns/1ps
// data_cache: direct-mapped, write-through, no-write-allocate data cache with
// one 32-bit word per line, sitting between a core and a backing memory.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   addr            core byte address (bits [1:0] ignored)
//   write_data      core store data
//   write_enable    core store request (takes priority over read_enable)
//   read_enable     core load request
//   read_data       load result, combinational on a hit, 0 otherwise
//   stall           core must hold its request stable while high
//   mem_req/mem_we  backing-memory request valid / write (1) or read (0)
//   mem_addr        word-aligned backing address
//   mem_wdata       backing store data
//   mem_ack         one-cycle completion from backing memory
//   mem_rdata       fill data, valid with mem_ack
module data_cache #(
    parameter int NUM_LINES  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           write_data,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [31:0]           read_data,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    state_t state_reg, state_next;
    // Set when a store has been acknowledged, so the still-presented store
    // request is released for one cycle instead of being issued again.
    logic   done_reg, done_next;

    logic [NUM_LINES-1:0] valid_reg;
    logic [NUM_LINES-1:0] line_fill;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES];

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IDX_W-1:0]      index;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic                  fill_wr;
    logic                  store_wr;

    assign word_addr = addr & WORD_MASK;
    assign index     = word_addr[IDX_W+1:2];
    assign tag       = word_addr[ADDR_WIDTH-1:IDX_W+2];
    assign hit       = valid_reg[index] && (tag_mem[index] == tag);

    // A reset coinciding with an acknowledge abandons the transfer entirely.
    assign fill_wr  = (state_reg == FILL)  && mem_ack && !rst;
    assign store_wr = (state_reg == WRITE) && mem_ack && hit && !rst;

    // Per-line set strobe for the valid bits.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            assign line_fill[gi] = fill_wr && (index == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_reg | line_fill;
        end
    end

    // Tag/data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= mem_rdata;
        end else if (store_wr) begin
            data_mem[index] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = done_reg;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        read_data  = '0;
        case (state_reg)
            IDLE: begin
                done_next = 1'b0;
                if (write_enable) begin
                    if (!done_reg) begin
                        stall      = 1'b1;
                        state_next = WRITE;
                    end
                end else if (read_enable) begin
                    if (hit) begin
                        read_data = data_mem[index];
                    end else begin
                        stall      = 1'b1;
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = word_addr;
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = write_data;
                if (mem_ack) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter: NUM_LINES, default 64, number of one-word lines (power of two, 2..1024).
REQ-002 Parameter: ADDR_WIDTH, default 32, byte-address width.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 addr  input  ADDR_WIDTH  core byte address; bits [1:0] are ignored.
REQ-007 write_data  input  32  core store data.
REQ-008 write_enable  input  1  core store request.
REQ-009 read_enable  input  1  core load request.
REQ-010 read_data  output  32  load result, combinational on a hit.
REQ-011 stall  output  1  core must hold addr, write_data and the enables stable while this is high.
REQ-012 mem_req  output  1  backing-memory request valid.
REQ-013 mem_we  output  1  backing-memory write (1) or read (0).
REQ-014 mem_addr  output  ADDR_WIDTH  word-aligned backing address, with bits [1:0] = 0.
REQ-015 mem_wdata  output  32  backing store data.
REQ-016 mem_ack  input  1  one-cycle completion from backing memory.
REQ-017 mem_rdata  input  32  fill data, valid in the cycle mem_ack is high.

Function
REQ-018 Organisation: direct-mapped and write-through, with no write-allocate.
REQ-019 Address fields: index = addr[log2(NUM_LINES)+1:2]; tag = addr[ADDR_WIDTH-1:log2(NUM_LINES)+2].
REQ-020 Per-line storage: one valid bit, one tag and one 32-bit data word.
REQ-021 FSM states: IDLE, FILL, WRITE.
REQ-022 Hit definition: the line at the index is valid and its tag equals the address tag.
REQ-023 IDLE, read_enable=1, write_enable=0, hit: read_data = line data in the same cycle; stall=0; state stays IDLE.
REQ-024 IDLE, read_enable=1, write_enable=0, miss: stall=1 combinationally in the same cycle; next state FILL.
REQ-025 FILL outputs: mem_req=1, mem_we=0, mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}; stall=1.
REQ-026 FILL on mem_ack: the line is written with valid=1, the address tag and mem_rdata; next state IDLE.
REQ-027 Load completion after a fill: the next IDLE cycle hits, so stall=0 and read_data = the filled word.
REQ-028 Load-miss latency: a load miss with mem_ack arriving k cycles after mem_req rises stalls for k+2 cycles in total.
REQ-029 IDLE, write_enable=1: stall=1 in the same cycle; next state WRITE.
REQ-030 Store precedence: write_enable has priority over read_enable when both are high.
REQ-031 WRITE outputs: mem_req=1, mem_we=1, mem_addr = word-aligned addr, mem_wdata = write_data; stall=1.
REQ-032 WRITE on mem_ack, hit: the line data is updated to write_data; next state IDLE.
REQ-033 WRITE on mem_ack, miss: the line is left unchanged; next state IDLE.
REQ-034 Store completion: in the IDLE cycle after a store's mem_ack, stall=0 for one cycle so the core can advance; a store is not re-issued while the same request is still presented in that cycle.
REQ-035 Store re-issue guard: a done flag, cleared when stall=0 in IDLE, provides this behaviour.
REQ-036 Handshake: mem_req, mem_we, mem_addr and mem_wdata stay stable from request until mem_ack.
REQ-037 Handshake: mem_req drops in the cycle after mem_ack.
REQ-038 Handshake: mem_ack is ignored while mem_req=0.
REQ-039 Idle outputs: with no enables, stall=0, mem_req=0 and read_data is don't-care (driven 0).
REQ-040 Outside hit/fill: read_data = 0 whenever the cycle is not a hit or a post-fill hit.

Reset
REQ-041 rst=1 at a clock edge: state becomes IDLE, all valid bits clear, and the done flag clears.
REQ-042 Tag and data arrays need not be reset.
REQ-043 Outputs in the cycle after reset: mem_req=0 and stall=0, unless an enable is present.
REQ-044 Reset during FILL or WRITE: the request is abandoned, mem_req is low on the next cycle, no line is written, and a later stray mem_ack is ignored.

Verification
REQ-045 Cold load: after reset, load 0x0000_0040 with mem_ack 3 cycles after mem_req and mem_rdata=0xDEAD_BEEF -> stall is high for 5 cycles, mem_addr=0x40, mem_we=0, then read_data=0xDEAD_BEEF with stall=0.
REQ-046 Repeat hit: immediately reload 0x40 -> stall=0 and read_data=0xDEAD_BEEF in the same cycle with no mem_req.
REQ-047 Store hit: store 0x1234_5678 to 0x40 with ack after 1 cycle -> mem_we=1, mem_wdata=0x1234_5678; a subsequent load of 0x40 hits with 0x1234_5678.
REQ-048 Conflict miss: load 0x140 (same index as 0x40 at NUM_LINES=64, different tag) -> a miss fill occurs; a subsequent load of 0x40 misses again.
REQ-049 Store miss with no allocate: store to 0x80 -> the backing write occurs; a subsequent load of 0x80 misses.
REQ-050 Reset mid-fill: assert rst during FILL and then pulse mem_ack -> mem_req stays 0, and a load of the same address misses.
